// File: rtl/operand_forward_ctrl.sv
// Execute-stage forwarding and load-use hazard control: tracks EX/MEM/WB destinations
// and registers the operand mux selects for the instruction entering EX.
module operand_forward_ctrl #(
    parameter int REG_BITS           = 4,
    parameter int ZERO_REG_HARDWIRED = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_reg_write,
    input  logic                id_is_load,
    input  logic                flush,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic                mux_enable,
    output logic                stall
);

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic                reg_write;
        logic                is_load;
    } stage_t;

    stage_t     ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic       mux_enable_q, mux_enable_d;

    logic a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;

    function automatic logic hit(stage_t e, logic used, logic [REG_BITS-1:0] rs);
        logic zero_blocked;
        zero_blocked = (ZERO_REG_HARDWIRED != 0) && (e.rd == '0);
        return used && e.valid && e.reg_write && (e.rd == rs) && !zero_blocked;
    endfunction

    // Youngest producer wins: EX (01) over MEM (10) over WB (11).
    function automatic logic [1:0] pick(logic h_ex, logic h_mem, logic h_wb);
        if (h_ex)       return 2'b01;
        else if (h_mem) return 2'b10;
        else if (h_wb)  return 2'b11;
        return 2'b00;
    endfunction

    always_comb begin
        a_ex  = hit(ex_q,  id_rs1_used, id_rs1);
        a_mem = hit(mem_q, id_rs1_used, id_rs1);
        a_wb  = hit(wb_q,  id_rs1_used, id_rs1);
        b_ex  = hit(ex_q,  id_rs2_used, id_rs2);
        b_mem = hit(mem_q, id_rs2_used, id_rs2);
        b_wb  = hit(wb_q,  id_rs2_used, id_rs2);

        // A load's result is not ready in EX; flush discards the consumer anyway.
        stall = id_valid && ex_q.is_load && (a_ex || b_ex) && !flush;

        mem_d        = ex_q;
        wb_d         = mem_q;
        ex_d         = '0;
        mux_enable_d = 1'b0;
        fwd_a_d      = 2'b00;
        fwd_b_d      = 2'b00;

        if (!stall && !flush && id_valid) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write;
            ex_d.is_load   = id_is_load;
            mux_enable_d   = 1'b1;
            fwd_a_d        = pick(a_ex, a_mem, a_wb);
            fwd_b_d        = pick(b_ex, b_mem, b_wb);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            fwd_a_q      <= 2'b00;
            fwd_b_q      <= 2'b00;
            mux_enable_q <= 1'b0;
        end else begin
            ex_q         <= ex_d;
            mem_q        <= mem_d;
            wb_q         <= wb_d;
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
            mux_enable_q <= mux_enable_d;
        end
    end

    assign fwd_a      = fwd_a_q;
    assign fwd_b      = fwd_b_q;
    assign mux_enable = mux_enable_q;

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Bench for operand_forward_ctrl: two instances (zero register normal / hardwired) share
// stimulus and are checked against a pipeline-history model of producers.
module tb_operand_forward_ctrl;

    logic       clk = 1'b0;
    logic       rst, id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_is_load, flush;
    logic [3:0] id_rs1, id_rs2, id_rd;
    logic [1:0] fa [2];
    logic [1:0] fb [2];
    logic       mx [2];
    logic       st [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    operand_forward_ctrl #(.REG_BITS(4), .ZERO_REG_HARDWIRED(0)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
        .fwd_a(fa[0]), .fwd_b(fb[0]), .mux_enable(mx[0]), .stall(st[0]));

    operand_forward_ctrl #(.REG_BITS(4), .ZERO_REG_HARDWIRED(1)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
        .fwd_a(fa[1]), .fwd_b(fb[1]), .mux_enable(mx[1]), .stall(st[1]));

    // Model: p[d][k] is the instruction that is k+1 stages ahead of decode.
    typedef struct packed {
        bit       v;
        bit [3:0] rd;
        bit       w;
        bit       ld;
    } ent_t;

    ent_t     p [2][3];
    bit [1:0] efa [2];
    bit [1:0] efb [2];
    bit       emx [2];
    bit       lst;
    bit       hold;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit mm(int d, int k, bit used, bit [3:0] rs);
        return used && p[d][k].v && p[d][k].w && (p[d][k].rd == rs) && !(d == 1 && rs == 0);
    endfunction

    function automatic bit [1:0] pick(int d, bit used, bit [3:0] rs);
        for (int k = 0; k < 3; k++)
            if (mm(d, k, used, rs)) return 2'(k + 1);
        return 2'b00;
    endfunction

    task automatic setin(input bit v, input bit [3:0] r1, input bit u1, input bit [3:0] r2,
                         input bit u2, input bit [3:0] rd, input bit w, input bit ld);
        id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
        id_rd = rd; id_reg_write = w; id_is_load = ld;
    endtask

    task automatic step();
        bit       es;
        ent_t     n;
        bit [1:0] sa, sb;
        @(negedge clk);
        lst = st[0];
        for (int d = 0; d < 2; d++) begin
            es = id_valid && p[d][0].v && p[d][0].ld && !flush &&
                 (mm(d, 0, id_rs1_used, id_rs1) || mm(d, 0, id_rs2_used, id_rs2));
            chk($sformatf("stall%0d", d), st[d], es);
            chk($sformatf("fwd_a%0d", d), fa[d], efa[d]);
            chk($sformatf("fwd_b%0d", d), fb[d], efb[d]);
            chk($sformatf("mux_en%0d", d), mx[d], emx[d]);
            if (d == 0) hold = es;
            n = '0; sa = 2'b00; sb = 2'b00;
            if (!es && !flush && id_valid) begin
                n  = '{v: 1'b1, rd: id_rd, w: id_reg_write, ld: id_is_load};
                sa = pick(d, id_rs1_used, id_rs1);
                sb = pick(d, id_rs2_used, id_rs2);
            end
            if (rst) begin
                for (int k = 0; k < 3; k++) p[d][k] = '0;
                efa[d] = 2'b00; efb[d] = 2'b00; emx[d] = 1'b0;
            end else begin
                p[d][2] = p[d][1]; p[d][1] = p[d][0]; p[d][0] = n;
                efa[d] = sa; efb[d] = sb; emx[d] = n.v;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit [1:0] gap_exp [4];
        gap_exp = '{2'b01, 2'b10, 2'b11, 2'b00};
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) p[d][k] = '0;
            efa[d] = 2'b00; efb[d] = 2'b00; emx[d] = 1'b0;
        end

        // Reset held with a valid decode instruction
        rst = 1'b1; flush = 1'b0;
        setin(1, 3, 1, 3, 1, 3, 1, 0);
        step(); step();
        chk("rst_fwd_a", fa[0], 2'b00);
        chk("rst_mux", mx[0], 1'b0);
        chk("rst_stall", st[0], 1'b0);
        rst = 1'b0;
        setin(1, 3, 1, 0, 0, 0, 0, 0);
        step();
        chk("first_fwd_a", fa[0], 2'b00);
        chk("first_mux", mx[0], 1'b1);

        // Producer distance 1..4
        for (int g = 0; g < 4; g++) begin
            setin(1, 0, 0, 0, 0, 5, 1, 0); step();
            for (int f = 0; f < g; f++) begin
                setin(1, 0, 0, 0, 0, 9, 1, 0); step();
            end
            setin(1, 5, 1, 5, 1, 6, 1, 0); step();
            chk($sformatf("gap%0d_fwd_a", g), fa[0], gap_exp[g]);
            chk($sformatf("gap%0d_fwd_b", g), fb[0], gap_exp[g]);
        end

        // Load-use: one stall, bubble, then MEM forward
        setin(1, 0, 0, 0, 0, 7, 1, 1); step();
        setin(1, 2, 1, 7, 1, 8, 1, 0); step();
        chk("lu_stall", lst, 1'b1);
        chk("lu_bubble", mx[0], 1'b0);
        step();
        chk("lu_stall_clr", lst, 1'b0);
        chk("lu_fwd_b", fb[0], 2'b10);
        chk("lu_fwd_a", fa[0], 2'b00);
        chk("lu_mux", mx[0], 1'b1);

        // Youngest producer wins
        setin(1, 0, 0, 0, 0, 4, 1, 0); step(); step();
        setin(1, 4, 1, 0, 0, 10, 1, 0); step();
        chk("prio_fwd_a", fa[0], 2'b01);

        // Flush beats load-use stall
        setin(1, 0, 0, 0, 0, 1, 1, 1); step();
        setin(1, 1, 1, 0, 0, 11, 1, 0); flush = 1'b1; step();
        chk("fl_stall", lst, 1'b0);
        chk("fl_mux", mx[0], 1'b0);
        flush = 1'b0;
        setin(1, 1, 1, 0, 0, 12, 1, 0); step();
        chk("fl_next_stall", lst, 1'b0);
        chk("fl_next_fwd_a", fa[0], 2'b10);

        // Register 0 destination
        setin(1, 0, 0, 0, 0, 0, 1, 0); step();
        setin(1, 0, 1, 0, 0, 13, 1, 0); step();
        chk("zr0_fwd_a", fa[0], 2'b01);
        chk("zr1_fwd_a", fa[1], 2'b00);

        // Random traffic; decode holds while dut0 stalls
        hold = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!hold)
                setin($urandom_range(3) != 0, 4'($urandom_range(3)), 1'($urandom),
                      4'($urandom_range(3)), 1'($urandom), 4'($urandom_range(3)),
                      $urandom_range(3) != 0, $urandom_range(2) == 0);
            flush = ($urandom_range(9) == 0);
            rst   = ($urandom_range(99) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
